// File: rtl/saes64_ksched_ctrl.sv
// saes64_ksched_ctrl
// AES-128 key-schedule sequencer driving one riscv_crypto_fu_saes64 unit.
// A start pulse loads the cipher key into rk[0..1]; the block then runs ten
// rounds of ks1/ks2/ks2 FU operations to fill rk[2..21]. With
// SAES64_KSCHED_DEC_EN defined it additionally builds the decryption key
// store dk[] (imix of rk[2..19], plain copies of rk[0,1,20,21]).
//
// Ports
//   g_clk, g_resetn        clock (rising edge), async active-low reset
//   start                  begin expansion (ignored unless idle)
//   key_lo, key_hi         cipher key bytes 0..7 / 8..15, little-endian
//   busy, done             expansion in progress / one-cycle completion pulse
//   rk_raddr, rk_rdec      key-store read index (0..21) and dk select
//   rk_rdata               combinational read data, 0 for index 22..31
//   fu_valid, fu_rs1/rs2   FU request and operands
//   fu_enc_rcon            ks1 round-constant index
//   fu_op_ks1/ks2/imix     one-hot FU op select
//   fu_rd, fu_ready        FU result and result-valid
//
// Build option: SAES64_KSCHED_DEC_EN enables the decryption key store.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; store holds the last expansion
// KS1   | ks1 on rk[2r+1] with rcon r, result into t
// KS2L  | ks2(t, rk[2r]) -> rk[2r+2]
// KS2H  | ks2(rk[2r+2], rk[2r+1]) -> rk[2r+3], then next round
// IMIX  | imix(rk[i]) -> dk[i] for i = 2..19 (decryption build only)
// DONE  | one-cycle done pulse

module saes64_ksched_ctrl (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        start,
  input  logic [63:0] key_lo,
  input  logic [63:0] key_hi,
  output logic        busy,
  output logic        done,
  input  logic [4:0]  rk_raddr,
  input  logic        rk_rdec,
  output logic [63:0] rk_rdata,
  output logic        fu_valid,
  output logic [63:0] fu_rs1,
  output logic [63:0] fu_rs2,
  output logic [3:0]  fu_enc_rcon,
  output logic        fu_op_ks1,
  output logic        fu_op_ks2,
  output logic        fu_op_imix,
  input  logic [63:0] fu_rd,
  input  logic        fu_ready
);

  localparam logic [3:0] LAST_ROUND = 4'd9;
  localparam int         NKEYS      = 22;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KS1  = 3'd1,
    S_KS2L = 3'd2,
    S_KS2H = 3'd3,
`ifdef SAES64_KSCHED_DEC_EN
    S_IMIX = 3'd4,
`endif
    S_DONE = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [63:0] t_q, t_d;
  logic [63:0] rk_q [NKEYS];

  logic        rk_load;
  logic        rk_we;
  logic [4:0]  rk_wa;

  // Key-store indices for round r: lo/hi of the current key, lo/hi of the next.
  logic [4:0]  idx_lo, idx_hi, idx_nlo, idx_nhi;
  assign idx_lo  = {r_q, 1'b0};
  assign idx_hi  = {r_q, 1'b1};
  assign idx_nlo = idx_lo + 5'd2;
  assign idx_nhi = idx_lo + 5'd3;

`ifdef SAES64_KSCHED_DEC_EN
  logic [63:0] dk_q [NKEYS];
  logic [4:0]  i_q, i_d;
  logic        dk_we;
  logic        dk_copy;
`else
  logic        unused_rdec;
  assign unused_rdec = rk_rdec;
`endif

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    t_d         = t_q;
    rk_load     = 1'b0;
    rk_we       = 1'b0;
    rk_wa       = 5'd0;
    busy        = 1'b0;
    done        = 1'b0;
    fu_valid    = 1'b0;
    fu_rs1      = 64'd0;
    fu_rs2      = 64'd0;
    fu_enc_rcon = 4'd0;
    fu_op_ks1   = 1'b0;
    fu_op_ks2   = 1'b0;
    fu_op_imix  = 1'b0;
`ifdef SAES64_KSCHED_DEC_EN
    i_d         = i_q;
    dk_we       = 1'b0;
    dk_copy     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_load = 1'b1;
          r_d     = 4'd0;
          state_d = S_KS1;
        end
      end
      S_KS1: begin
        busy        = 1'b1;
        fu_valid    = 1'b1;
        fu_op_ks1   = 1'b1;
        fu_rs1      = rk_q[idx_hi];
        fu_enc_rcon = r_q;
        if (fu_ready) begin
          t_d     = fu_rd;
          state_d = S_KS2L;
        end
      end
      S_KS2L: begin
        busy      = 1'b1;
        fu_valid  = 1'b1;
        fu_op_ks2 = 1'b1;
        fu_rs1    = t_q;
        fu_rs2    = rk_q[idx_lo];
        if (fu_ready) begin
          rk_we   = 1'b1;
          rk_wa   = idx_nlo;
          state_d = S_KS2H;
        end
      end
      S_KS2H: begin
        busy      = 1'b1;
        fu_valid  = 1'b1;
        fu_op_ks2 = 1'b1;
        fu_rs1    = rk_q[idx_nlo];
        fu_rs2    = rk_q[idx_hi];
        if (fu_ready) begin
          rk_we = 1'b1;
          rk_wa = idx_nhi;
          if (r_q == LAST_ROUND) begin
`ifdef SAES64_KSCHED_DEC_EN
            i_d     = 5'd2;
            state_d = S_IMIX;
`else
            state_d = S_DONE;
`endif
          end else begin
            r_d     = r_q + 4'd1;
            state_d = S_KS1;
          end
        end
      end
`ifdef SAES64_KSCHED_DEC_EN
      S_IMIX: begin
        busy       = 1'b1;
        fu_valid   = 1'b1;
        fu_op_imix = 1'b1;
        fu_rs1     = rk_q[i_q];
        // Re-copying during FU wait cycles is harmless: rk is stable here.
        dk_copy    = (i_q == 5'd2);
        if (fu_ready) begin
          dk_we = 1'b1;
          if (i_q == 5'd19) begin
            state_d = S_DONE;
          end else begin
            i_d = i_q + 5'd1;
          end
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      r_q     <= 4'd0;
      t_q     <= 64'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      t_q     <= t_d;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int k = 0; k < NKEYS; k++) rk_q[k] <= 64'd0;
    end else begin
      if (rk_load) begin
        rk_q[0] <= key_lo;
        rk_q[1] <= key_hi;
      end
      if (rk_we) rk_q[rk_wa] <= fu_rd;
    end
  end

`ifdef SAES64_KSCHED_DEC_EN
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      i_q <= 5'd0;
      for (int k = 0; k < NKEYS; k++) dk_q[k] <= 64'd0;
    end else begin
      i_q <= i_d;
      if (dk_copy) begin
        dk_q[0]  <= rk_q[0];
        dk_q[1]  <= rk_q[1];
        dk_q[20] <= rk_q[20];
        dk_q[21] <= rk_q[21];
      end
      if (dk_we) dk_q[i_q] <= fu_rd;
    end
  end
`endif

  always_comb begin
    rk_rdata = 64'd0;
    if (rk_raddr < 5'd22) begin
`ifdef SAES64_KSCHED_DEC_EN
      rk_rdata = rk_rdec ? dk_q[rk_raddr] : rk_q[rk_raddr];
`else
      rk_rdata = rk_q[rk_raddr];
`endif
    end
  end

endmodule

// File: tb/tb_saes64_ksched_ctrl.sv
// Testbench for saes64_ksched_ctrl: plays the saes64 FU (with configurable or
// random wait cycles) and checks the key store against a byte-level AES-128
// key expansion. Honors SAES64_KSCHED_DEC_EN for the decryption store.

module tb_saes64_ksched_ctrl;

`ifdef SAES64_KSCHED_DEC_EN
  localparam int NOPS = 48;
`else
  localparam int NOPS = 30;
`endif
  localparam logic [63:0] FL = 64'ha6d2ae2816157e2b;
  localparam logic [63:0] FH = 64'h3c4fcf098815f7ab;

  logic        g_clk = 1'b0;
  logic        g_resetn, start;
  logic [63:0] key_lo, key_hi;
  logic        busy, done;
  logic [4:0]  rk_raddr;
  logic        rk_rdec;
  logic [63:0] rk_rdata;
  logic        fu_valid;
  logic [63:0] fu_rs1, fu_rs2;
  logic [3:0]  fu_enc_rcon;
  logic        fu_op_ks1, fu_op_ks2, fu_op_imix;
  logic [63:0] fu_rd;
  logic        fu_ready;

  always #100 g_clk = ~g_clk;

  saes64_ksched_ctrl dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start),
    .key_lo(key_lo), .key_hi(key_hi), .busy(busy), .done(done),
    .rk_raddr(rk_raddr), .rk_rdec(rk_rdec), .rk_rdata(rk_rdata),
    .fu_valid(fu_valid), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
    .fu_enc_rcon(fu_enc_rcon), .fu_op_ks1(fu_op_ks1), .fu_op_ks2(fu_op_ks2),
    .fu_op_imix(fu_op_imix), .fu_rd(fu_rd), .fu_ready(fu_ready)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sbox   [256];
  logic [63:0] ref_rk [22];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'd0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'd0;
      for (int c = 1; c < 256; c++)
        if (gm(8'(v), 8'(c)) == 8'd1) inv = 8'(c);
      sbox[v] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-oriented expansion over a flat byte array.
  task automatic ref_expand(input logic [63:0] lo, input logic [63:0] hi);
    logic [7:0] ek [176];
    logic [7:0] tmp [4];
    logic [7:0] rc, x;
    for (int b = 0; b < 8; b++) begin
      ek[b]     = lo[8*b +: 8];
      ek[8 + b] = hi[8*b +: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int k = 0; k < 4; k++) tmp[k] = ek[4*(i-1) + k];
      if (i % 4 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rc;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[x];
        rc     = xt(rc);
      end
      for (int k = 0; k < 4; k++) ek[4*i + k] = ek[4*(i-4) + k] ^ tmp[k];
    end
    for (int j = 0; j < 22; j++)
      for (int b = 0; b < 8; b++) ref_rk[j][8*b +: 8] = ek[8*j + b];
  endtask

  function automatic logic [63:0] inv_mix(input logic [63:0] a);
    logic [63:0] r;
    logic [7:0]  s0, s1, s2, s3;
    for (int c = 0; c < 2; c++) begin
      s0 = a[32*c +: 8]; s1 = a[32*c+8 +: 8]; s2 = a[32*c+16 +: 8]; s3 = a[32*c+24 +: 8];
      r[32*c    +: 8] = gm(s0, 8'h0e) ^ gm(s1, 8'h0b) ^ gm(s2, 8'h0d) ^ gm(s3, 8'h09);
      r[32*c+8  +: 8] = gm(s0, 8'h09) ^ gm(s1, 8'h0e) ^ gm(s2, 8'h0b) ^ gm(s3, 8'h0d);
      r[32*c+16 +: 8] = gm(s0, 8'h0d) ^ gm(s1, 8'h09) ^ gm(s2, 8'h0e) ^ gm(s3, 8'h0b);
      r[32*c+24 +: 8] = gm(s0, 8'h0b) ^ gm(s1, 8'h0d) ^ gm(s2, 8'h09) ^ gm(s3, 8'h0e);
    end
    return r;
  endfunction

  // Behaviour of the saes64 FU for the three ops this block uses.
  function automatic logic [63:0] fu_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [3:0] rn);
    logic [7:0]  w [4];
    logic [31:0] t, lo;
    logic [7:0]  rc;
    if (op == 3'b001) begin
      for (int k = 0; k < 4; k++) w[k] = a[32 + 8*k +: 8];
      rc = 8'h01;
      for (int k = 0; k < int'(rn); k++) rc = xt(rc);
      t = {sbox[w[0]], sbox[w[3]], sbox[w[2]], sbox[w[1]]};
      t[7:0] = t[7:0] ^ rc;
      return {t, t};
    end else if (op == 3'b010) begin
      lo = a[63:32] ^ b[31:0];
      return {lo ^ b[63:32], lo};
    end
    return inv_mix(a);
  endfunction

  task automatic rd(input int a, input logic dec, output logic [63:0] v);
    rk_raddr = 5'(a);
    rk_rdec  = dec;
    #1;
    v = rk_rdata;
  endtask

  task automatic check_zero(input string tag);
    logic [63:0] v;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_fu_valid"}, 64'(fu_valid), 64'd0);
    chk({tag, "_ops"}, 64'({fu_op_imix, fu_op_ks2, fu_op_ks1}), 64'd0);
    chk({tag, "_rs1"}, fu_rs1, 64'd0);
    chk({tag, "_rs2"}, fu_rs2, 64'd0);
    chk({tag, "_rcon"}, 64'(fu_enc_rcon), 64'd0);
    for (int a = 0; a < 22; a++) begin
      rd(a, 1'b0, v);
      chk($sformatf("%s_rk%0d", tag, a), v, 64'd0);
`ifdef SAES64_KSCHED_DEC_EN
      rd(a, 1'b1, v);
      chk($sformatf("%s_dk%0d", tag, a), v, 64'd0);
`endif
    end
  endtask

  task automatic check_store(input string tag);
    logic [63:0] v, e;
    for (int a = 0; a < 22; a++) begin
      rd(a, 1'b0, v);
      chk($sformatf("%s_rk%0d", tag, a), v, ref_rk[a]);
`ifdef SAES64_KSCHED_DEC_EN
      e = (a < 2 || a > 19) ? ref_rk[a] : inv_mix(ref_rk[a]);
      rd(a, 1'b1, v);
      chk($sformatf("%s_dk%0d", tag, a), v, e);
`else
      e = ref_rk[a];
      rd(a, 1'b1, v);
      chk($sformatf("%s_rdec_ignored%0d", tag, a), v, e);
`endif
    end
    rd(25, 1'b0, v);
    chk({tag, "_addr25"}, v, 64'd0);
    rd(25, 1'b1, v);
    chk({tag, "_addr25_dec"}, v, 64'd0);
  endtask

  // One expansion. waitn < 0 draws 0..3 wait cycles per op. Cycle 0 samples
  // start; dc returns the cycle in which done was seen (-1 if never).
  task automatic expand(input string tag, input logic [63:0] lo, input logic [63:0] hi,
                        input int waitn, input int st_a, input int st_b,
                        input bit st_in_done, input int rst_cyc, output int dc);
    int         ops, wcnt, wtarget, exp_done, ks1_cnt, done_cnt;
    bit         prev_valid, prev_ready, fin;
    logic [2:0] opv, exp_op, s_op;
    logic [63:0] s_rs1, s_rs2;
    logic [3:0] s_rcon;
    bit         exp_busy;
    ref_expand(lo, hi);
    @(negedge g_clk);
    key_lo = lo; key_hi = hi; start = 1'b1; fu_ready = 1'b0;
    prev_valid = 0; prev_ready = 0; ops = 0; exp_done = 1; ks1_cnt = 0;
    done_cnt = 0; dc = -1; fin = 0; wcnt = 0; wtarget = 0;
    s_op = 3'd0; s_rs1 = 64'd0; s_rs2 = 64'd0; s_rcon = 4'd0;
    for (int c = 1; c <= 600 && !fin; c++) begin
      @(negedge g_clk);
      start  = (c == st_a || c == st_b);
      key_lo = {$urandom, $urandom};
      key_hi = {$urandom, $urandom};
      if (c == rst_cyc) begin
        g_resetn = 1'b0;
        fu_ready = 1'b0;
        start    = 1'b0;
        #1;
        check_zero({tag, "_abort"});
        fin = 1;
      end else begin
        opv = {fu_op_imix, fu_op_ks2, fu_op_ks1};
        if (fu_valid) begin
          if (!prev_valid || prev_ready) begin
            exp_op = (ops >= 30) ? 3'b100 : ((ops % 3 == 0) ? 3'b001 : 3'b010);
            chk($sformatf("%s_op%0d_sel", tag, ops), 64'(opv), 64'(exp_op));
            if (fu_op_ks1) begin
              chk($sformatf("%s_rcon%0d", tag, ks1_cnt), 64'(fu_enc_rcon), 64'(ks1_cnt));
              ks1_cnt++;
            end
            s_op = opv; s_rs1 = fu_rs1; s_rs2 = fu_rs2; s_rcon = fu_enc_rcon;
            wtarget  = (waitn < 0) ? int'($urandom_range(0, 3)) : waitn;
            exp_done = exp_done + wtarget + 1;
            wcnt     = 0;
            ops++;
          end else begin
            chk({tag, "_hold_op"}, 64'(opv), 64'(s_op));
            chk({tag, "_hold_rs1"}, fu_rs1, s_rs1);
            chk({tag, "_hold_rs2"}, fu_rs2, s_rs2);
            chk({tag, "_hold_rcon"}, 64'(fu_enc_rcon), 64'(s_rcon));
          end
          if (wcnt == wtarget) begin
            fu_ready = 1'b1;
            fu_rd    = fu_model(opv, fu_rs1, fu_rs2, fu_enc_rcon);
          end else begin
            fu_ready = 1'b0;
            fu_rd    = {$urandom, $urandom};
            wcnt++;
          end
        end else begin
          chk({tag, "_idle_ops"}, 64'(opv), 64'd0);
          fu_ready = 1'($urandom_range(0, 1));
          fu_rd    = {$urandom, $urandom};
        end
        prev_valid = fu_valid;
        prev_ready = fu_ready;
        exp_busy = (c < exp_done);
        chk($sformatf("%s_busy_c%0d", tag, c), 64'(busy), 64'(exp_busy));
        chk($sformatf("%s_valid_c%0d", tag, c), 64'(fu_valid), 64'(exp_busy));
        chk($sformatf("%s_done_c%0d", tag, c), 64'(done), 64'(c == exp_done && ops == NOPS));
        if (done) begin
          done_cnt++;
          if (dc < 0) dc = c;
          if (st_in_done) start = 1'b1;
        end
        fin = (ops == NOPS) && (c >= exp_done + (st_in_done ? 1 : 0));
      end
    end
    chk({tag, "_finished_in_budget"}, 64'(fin), 64'd1);
    if (rst_cyc < 0) begin
      chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      chk({tag, "_done_cycle"}, 64'(dc), 64'(exp_done));
      check_store(tag);
    end else begin
      chk({tag, "_done_count"}, 64'(done_cnt), 64'd0);
    end
  endtask

  task automatic fips_check(input string tag);
    logic [63:0] v;
    rd(2, 1'b0, v);  chk({tag, "_rk2"},  v, 64'hb12c548817fefaa0);
    rd(3, 1'b0, v);  chk({tag, "_rk3"},  v, 64'h05766c2a3939a323);
    rd(20, 1'b0, v); chk({tag, "_rk20"}, v, 64'h8925eec9a8f914d0);
    rd(21, 1'b0, v); chk({tag, "_rk21"}, v, 64'ha60c63b6c80c3fe1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    build_sbox();
    g_resetn = 1'b0; start = 1'b0; key_lo = 64'd0; key_hi = 64'd0;
    rk_raddr = 5'd0; rk_rdec = 1'b0; fu_rd = 64'd0; fu_ready = 1'b0;
    @(negedge g_clk);
    check_zero("reset");
    g_resetn = 1'b1;

    expand("fips", FL, FH, 0, -1, -1, 0, -1, dc);
    chk("fips_done_cycle", 64'(dc), 64'(NOPS + 1));
    fips_check("fips");

    // Starts in the cycle right after the previous done.
    expand("wait2", FL, FH, 2, -1, -1, 0, -1, dc);
    chk("wait2_done_cycle", 64'(dc), 64'(3 * NOPS + 1));
    fips_check("wait2");

    expand("dupstart", FL, FH, 0, 5, 20, 1, -1, dc);
    chk("dupstart_done_cycle", 64'(dc), 64'(NOPS + 1));
    fips_check("dupstart");

    expand("abort", FL, FH, 0, -1, -1, 0, 12, dc);
    @(negedge g_clk);
    g_resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge g_clk);
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    expand("after_abort", FL, FH, 0, -1, -1, 0, -1, dc);
    chk("after_abort_done_cycle", 64'(dc), 64'(NOPS + 1));
    fips_check("after_abort");

    for (int n = 0; n < 4; n++)
      expand($sformatf("rand%0d", n), {$urandom, $urandom}, {$urandom, $urandom},
             -1, -1, -1, 0, -1, dc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/saes64_ksched_ctrl.md
# saes64_ksched_ctrl

AES-128 key-schedule sequencer for one `riscv_crypto_fu_saes64` unit. A requester supplies a 128-bit cipher key. The block drives the FU through ks1/ks2 operations to expand all 11 round keys (and, when configured, the imix-transformed decryption keys) into an internal 22×64 key store. A combinational read port exposes the stored keys to the cipher datapath.

## Interface
- No parameters; AES-128 only: 10 rounds, 22 64-bit key halves.
- `g_clk` in 1: clock, rising edge.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse that begins an expansion; ignored while `busy`.
- `key_lo` in 64: key bytes 0..7, little-endian.
- `key_hi` in 64: key bytes 8..15, little-endian.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse when the key store is complete.
- `rk_raddr` in 5: key-store read index, 0..21; index 2r is the lo half and 2r+1 the hi half of round key r.
- `rk_rdec` in 1: selects the decryption key store. Ignored without the macro.
- `rk_rdata` out 64: combinational read data. Addresses 22..31 return 0.
- `fu_valid` out 1: FU request.
- `fu_rs1` out 64: FU source 1.
- `fu_rs2` out 64: FU source 2.
- `fu_enc_rcon` out 4: ks1 rcon index.
- `fu_op_ks1` out 1: one-hot FU op select.
- `fu_op_ks2` out 1: one-hot FU op select.
- `fu_op_imix` out 1: one-hot FU op select.
- `fu_rd` in 64: FU result.
- `fu_ready` in 1: FU result valid.
- The integrator ties the FU's encs/encsm/decs/decsm inputs to 0.

## Operation
- States: IDLE, KS1, KS2L, KS2H, IMIX, DONE.
- IDLE with `start`=1: write rk[0]=`key_lo` and rk[1]=`key_hi`, clear round counter r, go to KS1.
- Round r (0..9) issues three FU ops; t is an internal 64-bit register:
  - KS1: rs1=rk[2r+1], rs2=0, rcon=r. On `fu_ready`, t←`fu_rd`.
  - KS2L: rs1=t, rs2=rk[2r]. On `fu_ready`, rk[2r+2]←`fu_rd`.
  - KS2H: rs1=rk[2r+2], rs2=rk[2r+1]. On `fu_ready`, rk[2r+3]←`fu_rd`. Then r++ and return to KS1. After r=9, go to DONE (or IMIX when the macro is defined).
- FU handshake:
  - `fu_valid`=1 in every op state.
  - Operands and op select stay stable until the cycle `fu_ready`=1.
  - The result is captured in that cycle; the next op may issue in the following cycle with `fu_valid` held high.
  - `fu_ready` is ignored while `fu_valid`=0.
- Exactly one `fu_op_*` is high while `fu_valid`=1; all are 0 otherwise.
- DONE: `done`=1 for one cycle, then go to IDLE.
- The key store persists after completion until the next `start` overwrites it. Reads while `busy` return partially updated contents; this is legal and undefined for the consumer.

## Timing
- Reset values:
  - state=IDLE; `busy`=0; `done`=0; `fu_valid`=0; all `fu_op_*`=0.
  - `fu_rs1`, `fu_rs2`, `fu_enc_rcon` = 0.
  - Key stores, t and r cleared.
- Reset asserted mid-expansion aborts immediately: no `done`, and the store is cleared.
- Single-cycle FU (`fu_ready` high the same cycle as `fu_valid`), with `start` sampled in cycle 0:
  - Ops occupy cycles 1..30.
  - `busy`=1 in cycles 1..30.
  - `done`=1 in cycle 31.
- Each FU wait cycle adds exactly one cycle to latency.
- `start` arriving in the DONE cycle is ignored.
- `start` arriving in IDLE one cycle after `done` is accepted.

## Configuration
- Macro: `SAES64_KSCHED_DEC_EN`.
- Defined:
  - After round 9, enter IMIX.
  - Copy dk[0,1,20,21] ← rk[0,1,20,21] in the first IMIX cycle.
  - Issue imix with rs1=rk[i] for i=2..19 in ascending order, writing dk[i]←`fu_rd` on each `fu_ready`, then go to DONE.
  - Adds 18 ops: `done` in cycle 49 with a single-cycle FU.
  - `rk_rdec`=1 reads dk.
- Undefined:
  - No dk storage, no IMIX state.
  - `fu_op_imix` is constant 0 and `rk_rdec` is ignored.

## Test plan
- FIPS-197 key: `key_lo`=0xa6d2ae2816157e2b, `key_hi`=0x3c4fcf098815f7ab, single-cycle FU. Required: rk[2]=0xb12c548817fefaa0, rk[3]=0x05766c2a3939a323, rk[20]=0x8925eec9a8f914d0, rk[21]=0xa60c63b6c80c3fe1, and `done` in cycle 31.
- FU with 2 wait cycles per op: same keys as above. `done` in cycle 91; operands and op select stable across every wait cycle.
- `start` pulsed at cycles 5 and 20 of an expansion: ignored; results match the first key; exactly one `done`.
- `g_resetn` pulsed low at cycle 12:
  - outputs and store are 0 immediately;
  - no `done`;
  - a new `start` then completes normally.
- With `SAES64_KSCHED_DEC_EN`, FIPS key:
  - dk[0..1] and dk[20..21] equal the matching rk entries;
  - dk[i] equals InvMixColumns of rk[i] for i=2..19, checked against the FU's imix result;
  - `done` in cycle 49.
- Every FU request: one-hot op select; `fu_enc_rcon`=r during KS1 for r=0..9; `rk_raddr`=25 reads 0.
